// File: rtl/cmpt_pkg.sv
// rtl/cmpt_pkg.sv - shared constants and types for the compute issue scheduler
//
// Purpose: unit one-hot encodings, register-file geometry, the reservation
// entry layout and the unit-select decode shared by the scheduler files.
package cmpt_pkg;

  localparam int REG_AW  = 4;
  localparam int REG_CNT = 16;

  localparam logic [2:0] CU_ALU = 3'b001;
  localparam logic [2:0] CU_MUL = 3'b010;
  localparam logic [2:0] CU_SHF = 3'b100;

  // One slot of the write-back reservation pipe.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] addr;
    logic [2:0]        unit;
  } resv_entry_t;

  // Malformed selects resolve ALU > MUL > SHF; an empty select means ALU.
  function automatic logic [2:0] cu_decode(input logic [2:0] unit);
    if (unit[0] || (unit == 3'b000)) begin
      return CU_ALU;
    end else if (unit[1]) begin
      return CU_MUL;
    end else begin
      return CU_SHF;
    end
  endfunction

endpackage

// File: rtl/cmpt_wb_resv.sv
// rtl/cmpt_wb_resv.sv - write-back reservation shift pipe P[1..MUL_LAT]
//
// Purpose: holds one entry per future write-back cycle. Every clock the pipe
// shifts toward P[1]; a dispatched writer is dropped into slot ins_lat_i.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush_i         clear every slot at the next edge
//   ins_vld_i       insert ins_entry_i at slot ins_lat_i (post-shift index)
//   ins_lat_i       result latency of the inserted instruction (1..MUL_LAT)
//   ins_entry_i     entry to insert
//   p1_o            head slot, i.e. the write happening this cycle
//   p2_vld_o        slot 2 occupied; the only collision a latency-1 unit can hit
module cmpt_wb_resv
  import cmpt_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        ins_vld_i,
  input  logic [3:0]  ins_lat_i,
  input  resv_entry_t ins_entry_i,
  output resv_entry_t p1_o,
  output logic        p2_vld_o
);

  resv_entry_t p_q [1:MUL_LAT];
  resv_entry_t p_d [1:MUL_LAT];

  always_comb begin
    for (int k = 1; k < MUL_LAT; k++) begin
      p_d[k] = p_q[k+1];
    end
    p_d[MUL_LAT] = '0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      if (ins_vld_i && (ins_lat_i == 4'(k))) begin
        p_d[k] = ins_entry_i;
      end
    end
    if (flush_i) begin
      for (int k = 1; k <= MUL_LAT; k++) begin
        p_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= MUL_LAT; k++) begin
        p_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= MUL_LAT; k++) begin
        p_q[k] <= p_d[k];
      end
    end
  end

  assign p1_o     = p_q[1];
  assign p2_vld_o = p_q[2].vld;

endmodule

// File: rtl/cmpt_issue_sched.sv
// rtl/cmpt_issue_sched.sv - issue scheduler for the ALU / multiplier / shifter
//
// Purpose: stalls a decoded compute instruction on RAW, WAW or write-port
// conflicts, tracks pending writes in a per-register scoreboard and presents
// the register-file write (wb_*) in the cycle the result arrives.
// Optional feature macro: CMPT_BYPASS_EN (a source retiring in P[1] this
// cycle is forwarded by the register file and does not stall).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   iss_vld, iss_unit             instruction present, one-hot unit select
//   iss_ra_vld/iss_ra, iss_rb_vld/iss_rb   source reads
//   iss_wr_vld, iss_wa            destination write
//   flush                         cancel all in-flight write-backs
//   iss_stall, iss_go             combinational hold / dispatch
//   wb_en, wb_addr, wb_unit       registered register-file write
//   busy                          registered scoreboard, one bit per register
module cmpt_issue_sched
  import cmpt_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_vld,
  input  logic [2:0]         iss_unit,
  input  logic               iss_ra_vld,
  input  logic               iss_rb_vld,
  input  logic [REG_AW-1:0]  iss_ra,
  input  logic [REG_AW-1:0]  iss_rb,
  input  logic               iss_wr_vld,
  input  logic [REG_AW-1:0]  iss_wa,
  input  logic               flush,
  output logic               iss_stall,
  output logic               iss_go,
  output logic               wb_en,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [2:0]         wb_unit,
  output logic [REG_CNT-1:0] busy
);

  logic [2:0]         unit_dec;
  logic               is_mul;
  logic [3:0]         lat;
  resv_entry_t        ins_entry;
  resv_entry_t        p1;
  logic               p2_vld;
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;
  logic               ra_byp;
  logic               rb_byp;
  logic               raw_a;
  logic               raw_b;
  logic               waw;
  logic               structural;
  logic               wr_go;

  assign unit_dec  = cu_decode(iss_unit);
  assign is_mul    = (unit_dec == CU_MUL);
  assign lat       = is_mul ? 4'(MUL_LAT) : 4'd1;
  assign ins_entry = '{vld: 1'b1, addr: iss_wa, unit: unit_dec};

`ifdef CMPT_BYPASS_EN
  assign ra_byp = p1.vld && (p1.addr == iss_ra);
  assign rb_byp = p1.vld && (p1.addr == iss_rb);
`else
  assign ra_byp = 1'b0;
  assign rb_byp = 1'b0;
`endif

  assign raw_a = iss_ra_vld && busy_q[iss_ra] && !ra_byp;
  assign raw_b = iss_rb_vld && busy_q[iss_rb] && !rb_byp;

  // A register retiring in P[1] frees up this cycle, so re-targeting it is safe.
  assign waw = iss_wr_vld && busy_q[iss_wa] && !(p1.vld && (p1.addr == iss_wa));

  // The multiplier lands on the newest slot, which is always empty after the
  // shift; only latency-1 units can collide, and they target P[2] pre-shift.
  assign structural = iss_wr_vld && !is_mul && p2_vld;

  assign iss_stall = iss_vld && (structural || raw_a || raw_b || waw);
  assign iss_go    = iss_vld && !iss_stall && !flush;
  assign wr_go     = iss_go && iss_wr_vld;

  cmpt_wb_resv #(
    .MUL_LAT (MUL_LAT)
  ) u_resv (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .ins_vld_i   (wr_go),
    .ins_lat_i   (lat),
    .ins_entry_i (ins_entry),
    .p1_o        (p1),
    .p2_vld_o    (p2_vld)
  );

  // Clear before set so a register re-targeted while retiring stays busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (p1.vld) begin
        busy_d[p1.addr] = 1'b0;
      end
      if (wr_go) begin
        busy_d[iss_wa] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign wb_en   = p1.vld;
  assign wb_addr = p1.addr;
  assign wb_unit = p1.unit;

endmodule

// File: tb/tb_cmpt_issue_sched.sv
// tb/tb_cmpt_issue_sched.sv - scoreboard bench for cmpt_issue_sched
module tb_cmpt_issue_sched;

  localparam int MUL_LAT = 3;
`ifdef CMPT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_vld = 1'b0;
  logic [2:0]  iss_unit = 3'b000;
  logic        iss_ra_vld = 1'b0;
  logic        iss_rb_vld = 1'b0;
  logic [3:0]  iss_ra = 4'd0;
  logic [3:0]  iss_rb = 4'd0;
  logic        iss_wr_vld = 1'b0;
  logic [3:0]  iss_wa = 4'd0;
  logic        flush = 1'b0;
  logic        iss_stall;
  logic        iss_go;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [2:0]  wb_unit;
  logic [15:0] busy;

  always #5 clk = ~clk;

  cmpt_issue_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_vld    (iss_vld),
    .iss_unit   (iss_unit),
    .iss_ra_vld (iss_ra_vld),
    .iss_rb_vld (iss_rb_vld),
    .iss_ra     (iss_ra),
    .iss_rb     (iss_rb),
    .iss_wr_vld (iss_wr_vld),
    .iss_wa     (iss_wa),
    .flush      (flush),
    .iss_stall  (iss_stall),
    .iss_go     (iss_go),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_unit    (wb_unit),
    .busy       (busy)
  );

  // Reference model: outstanding writes as {cycle, reg, unit} and, per
  // register, the cycle of its latest pending write (-1 when none).
  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [2:0] unit;
  } wr_t;

  wr_t expq[$];
  int  pend[16];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mon_idx;
  bit  dummy;
  int  waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit reg_busy(input logic [3:0] r);
    return pend[r] >= cyc;
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = reg_busy(4'(r));
    return b;
  endfunction

  function automatic bit src_blocked(input logic [3:0] r);
    return reg_busy(r) && !(BYP && (pend[r] == cyc));
  endfunction

  task automatic model_clear();
    expq.delete();
    for (int r = 0; r < 16; r++) pend[r] = -1;
  endtask

  // Monitor: every cycle the write due now must appear on wb_*, and nothing else.
  always @(negedge clk) begin
    mon_idx = -1;
    foreach (expq[i]) if (expq[i].cyc == cyc) mon_idx = i;
    if (mon_idx >= 0) begin
      chk("wb_en", 32'(wb_en), 32'd1);
      chk("wb_addr", 32'(wb_addr), 32'(expq[mon_idx].addr));
      chk("wb_unit", 32'(wb_unit), 32'(expq[mon_idx].unit));
      expq.delete(mon_idx);
    end else begin
      chk("wb_en_idle", 32'(wb_en), 32'd0);
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit v, input logic [2:0] u, input bit rav, input logic [3:0] ra,
                      input bit rbv, input logic [3:0] rb, input bit wv, input logic [3:0] wa,
                      input bit fl, output bit went);
    logic [2:0] du;
    int         lat;
    bit         st;
    wr_t        w;
    iss_vld = v; iss_unit = u; iss_ra_vld = rav; iss_ra = ra;
    iss_rb_vld = rbv; iss_rb = rb; iss_wr_vld = wv; iss_wa = wa; flush = fl;
    #1;
    du  = (u[0] || u == 3'b000) ? 3'b001 : (u[1] ? 3'b010 : 3'b100);
    lat = (du == 3'b010) ? MUL_LAT : 1;
    st  = 1'b0;
    if (v) begin
      if (wv) foreach (expq[i]) if (expq[i].cyc == cyc + lat) st = 1'b1;
      if (rav && src_blocked(ra)) st = 1'b1;
      if (rbv && src_blocked(rb)) st = 1'b1;
      if (wv && reg_busy(wa) && pend[wa] != cyc) st = 1'b1;
    end
    went = v && !st && !fl;
    chk("iss_stall", 32'(iss_stall), 32'(st));
    chk("iss_go", 32'(iss_go), 32'(went));
    chk("busy", 32'(busy), 32'(model_busy()));
    @(posedge clk);
    if (fl) begin
      for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].cyc > cyc) expq.delete(i);
      for (int r = 0; r < 16; r++) pend[r] = -1;
    end else if (went && wv) begin
      w.cyc = cyc + lat; w.addr = wa; w.unit = du;
      expq.push_back(w);
      pend[wa] = cyc + lat;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'b000, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, dummy);
  endtask

  // Retry one instruction until it dispatches; returns the stall count.
  task automatic issue_until(input logic [2:0] u, input bit rav, input logic [3:0] ra,
                             input bit wv, input logic [3:0] wa, output int n);
    bit g;
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      step(1, u, rav, ra, 0, 4'd0, wv, wa, 0, g);
      if (!g) n++;
    end
    if (!g) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: got no dispatch expected dispatch within 20 cycles");
    end
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_unit", 32'(wb_unit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_iss_go", 32'(iss_go), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); cyc++; #1;

    // ALU write to r5, no hazards.
    step(1, 3'b001, 0, 4'd0, 0, 4'd0, 1, 4'd5, 0, dummy);
    chk("alu_go", 32'(dummy), 32'd1);
    idle(3);

    // MUL r3 then ALU reading r3.
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd3, 0, dummy);
    issue_until(3'b001, 1, 4'd3, 1, 4'd4, waits);
    chk("raw_mul_waits", 32'(waits), BYP ? 32'd2 : 32'd3);
    idle(4);

    // MUL r1, bubble, ALU r2 collides with the MUL write slot.
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd1, 0, dummy);
    idle(1);
    issue_until(3'b001, 0, 4'd0, 1, 4'd2, waits);
    chk("struct_waits", 32'(waits), 32'd1);
    idle(4);

    // Back-to-back ALU writes to r7, then a read of r7.
    step(1, 3'b001, 0, 4'd0, 0, 4'd0, 1, 4'd7, 0, dummy);
    step(1, 3'b001, 0, 4'd0, 0, 4'd0, 1, 4'd7, 0, dummy);
    chk("waw_retire_go", 32'(dummy), 32'd1);
    issue_until(3'b100, 1, 4'd7, 0, 4'd0, waits);
    chk("raw_alu_waits", 32'(waits), BYP ? 32'd0 : 32'd1);
    idle(3);

    // MUL r9 then flush; the following reader of r9 must not stall.
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd9, 0, dummy);
    step(0, 3'b000, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, dummy);
    step(1, 3'b001, 1, 4'd9, 0, 4'd0, 1, 4'd8, 0, dummy);
    chk("post_flush_go", 32'(dummy), 32'd1);
    idle(5);

    // Three multiplies in flight, then reset mid-cycle.
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd10, 0, dummy);
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd11, 0, dummy);
    step(1, 3'b010, 0, 4'd0, 0, 4'd0, 1, 4'd12, 0, dummy);
    iss_vld = 1'b0; iss_wr_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_clear();
    chk("midrst_wb_en", 32'(wb_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); cyc++; #1;
    idle(MUL_LAT + 2);

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)),
           $urandom_range(0, 31) == 0, dummy);
    end
    idle(MUL_LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
